// File: rtl/max_pool_fill.sv
// Max-pool window fill sequencer.
// Emits one address and slot select per enabled cycle over a POOL x POOL window.
module max_pool_fill #(
  parameter int add_size  = 14,
  parameter int ROW_WIDTH = 28,
  parameter int POOL      = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [add_size-1:0] add_in,
  output logic [add_size-1:0] add_out,
  output logic [3:0]          sel,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          r_q, r_d;
  logic [1:0]          c_q, c_d;
  logic [add_size-1:0] base_q, base_d;
  logic [add_size-1:0] add_q, add_d;
  logic [3:0]          sel_q, sel_d;
  logic                done_q, done_d;

  logic                last;
  logic [1:0]          nr, nc;
  logic [add_size-1:0] off;

  assign last = (32'(r_q) == POOL - 1) && (32'(c_q) == POOL - 1);

  // Next row/col position and its address offset from the window base.
  always_comb begin
    nr = r_q;
    nc = c_q;
    if (32'(c_q) == POOL - 1) begin
      nc = 2'd0;
      nr = r_q + 2'd1;
    end else begin
      nc = c_q + 2'd1;
    end
    off = add_size'(32'(nr) * 32'(ROW_WIDTH) + 32'(nc));
  end

  // Sequencer next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    base_d  = base_q;
    add_d   = add_q;
    sel_d   = sel_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          base_d  = add_in;
          add_d   = add_in;
          sel_d   = 4'd0;
          r_d     = 2'd0;
          c_d     = 2'd0;
          done_d  = 1'b0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (enable) begin
          if (last) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            r_d   = nr;
            c_d   = nc;
            add_d = base_q + off;
            sel_d = 4'(32'(nr) * POOL + 32'(nc));
          end
        end
      end
      DONE: begin
        if (!enable) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      base_q  <= '0;
      add_q   <= '0;
      sel_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      base_q  <= base_d;
      add_q   <= add_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
    end
  end

  assign add_out = add_q;
  assign sel     = sel_q;
  assign done    = done_q;

endmodule

// File: tb/tb_max_pool_fill.sv
// Directed testbench for max_pool_fill.
// Default parameters: 14-bit addresses, row width 28, 2x2 window.
module tb_max_pool_fill;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [13:0] add_in;
  logic [13:0] add_out;
  logic [3:0]  sel;
  logic        done;

  int checks;
  int failures;

  max_pool_fill dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .add_in  (add_in),
    .add_out (add_out),
    .sel     (sel),
    .done    (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b0;
    add_in = 14'd0;
    tick();
    tick();
    checks++;
    if (add_out !== 14'd0 || sel !== 4'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: add_out=%0d sel=%0d done=%0b, required 0 0 0",
               add_out, sel, done);
    end
    reset = 1'b0;
    add_in = 14'd77;
    enable = 1'b1;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (add_out !== 14'd0 || sel !== 4'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: add_out=%0d sel=%0d done=%0b, required 0 0 0",
               add_out, sel, done);
    end
    enable = 1'b0;
    tick();
    #2;
    reset = 1'b0;
  endtask

  task automatic test_basic_fill();
    logic [13:0] ea [4];
    ea = '{14'd0, 14'd1, 14'd28, 14'd29};
    add_in = 14'd0;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (add_out !== ea[i] || sel !== 4'(i) || done !== 1'b0) begin
        failures++;
        $display("FAIL basic[%0d]: add_out=%0d sel=%0d done=%0b, required %0d %0d 0",
                 i, add_out, sel, done, ea[i], i);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (done !== 1'b1 || add_out !== 14'd29 || sel !== 4'd3) begin
        failures++;
        $display("FAIL basic_done[%0d]: add_out=%0d sel=%0d done=%0b, required 29 3 1",
                 i, add_out, sel, done);
      end
    end
    enable = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || add_out !== 14'd29) begin
      failures++;
      $display("FAIL basic_release: add_out=%0d done=%0b, required 29 0",
               add_out, done);
    end
  endtask

  task automatic test_offset();
    logic [13:0] ea [4];
    ea = '{14'd100, 14'd101, 14'd128, 14'd129};
    add_in = 14'd100;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) add_in = 14'd500;
      checks++;
      if (add_out !== ea[i] || sel !== 4'(i) || done !== 1'b0) begin
        failures++;
        $display("FAIL offset[%0d]: add_out=%0d sel=%0d done=%0b, required %0d %0d 0",
                 i, add_out, sel, done, ea[i], i);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || add_out !== 14'd129) begin
      failures++;
      $display("FAIL offset_done: add_out=%0d done=%0b, required 129 1",
               add_out, done);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_pause();
    add_in = 14'd0;
    enable = 1'b1;
    tick();
    tick();
    checks++;
    if (add_out !== 14'd1 || sel !== 4'd1) begin
      failures++;
      $display("FAIL pause_pre: add_out=%0d sel=%0d, required 1 1", add_out, sel);
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (add_out !== 14'd1 || sel !== 4'd1 || done !== 1'b0) begin
        failures++;
        $display("FAIL pause_hold[%0d]: add_out=%0d sel=%0d done=%0b, required 1 1 0",
                 i, add_out, sel, done);
      end
    end
    enable = 1'b1;
    tick();
    checks++;
    if (add_out !== 14'd28 || sel !== 4'd2) begin
      failures++;
      $display("FAIL pause_resume2: add_out=%0d sel=%0d, required 28 2", add_out, sel);
    end
    tick();
    checks++;
    if (add_out !== 14'd29 || sel !== 4'd3 || done !== 1'b0) begin
      failures++;
      $display("FAIL pause_resume3: add_out=%0d sel=%0d done=%0b, required 29 3 0",
               add_out, sel, done);
    end
    tick();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL pause_done: done=%0b, required 1", done);
    end
  endtask

  task automatic test_wrap();
    logic [13:0] ea [4];
    ea = '{14'd16383, 14'd0, 14'd27, 14'd28};
    enable = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL wrap_idle: done=%0b, required 0", done);
    end
    add_in = 14'd16383;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (add_out !== ea[i] || sel !== 4'(i) || done !== 1'b0) begin
        failures++;
        $display("FAIL wrap[%0d]: add_out=%0d sel=%0d done=%0b, required %0d %0d 0",
                 i, add_out, sel, done, ea[i], i);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || add_out !== 14'd28) begin
      failures++;
      $display("FAIL wrap_done: add_out=%0d done=%0b, required 28 1", add_out, done);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_reset_midfill();
    add_in = 14'd200;
    enable = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (add_out !== 14'd228 || sel !== 4'd2) begin
      failures++;
      $display("FAIL mid_pre: add_out=%0d sel=%0d, required 228 2", add_out, sel);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (add_out !== 14'd0 || sel !== 4'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: add_out=%0d sel=%0d done=%0b, required 0 0 0",
               add_out, sel, done);
    end
    tick();
    checks++;
    if (add_out !== 14'd0 || sel !== 4'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_hold: add_out=%0d sel=%0d done=%0b, required 0 0 0",
               add_out, sel, done);
    end
    add_in = 14'd300;
    #2;
    reset = 1'b0;
    tick();
    checks++;
    if (add_out !== 14'd300 || sel !== 4'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL mid_restart0: add_out=%0d sel=%0d done=%0b, required 300 0 0",
               add_out, sel, done);
    end
    tick();
    checks++;
    if (add_out !== 14'd301 || sel !== 4'd1) begin
      failures++;
      $display("FAIL mid_restart1: add_out=%0d sel=%0d, required 301 1", add_out, sel);
    end
    enable = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    enable   = 1'b0;
    add_in   = 14'd0;
    test_reset();
    test_basic_fill();
    test_offset();
    test_pause();
    test_wrap();
    test_reset_midfill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/max_pool_fill.md
Name: max_pool_fill

Overview:
- Address/select sequencer that fills the window registers of a max-pooling unit in the CNN datapath.
- Given the base address of a pooling window in feature-map memory, it emits one memory address per cycle for every element of the POOL x POOL window, plus a select code naming the window slot the returned data is loaded into.
- Asserts done when the window is complete; the max-pool compare stage then consumes the filled registers.

Parameters:
- add_size, 14, width of memory addresses (add_in, add_out).
- ROW_WIDTH, 28, feature-map row length in words; address step between window rows.
- POOL, 2, pooling window edge. Legal range 1..4, so POOL*POOL <= 16 fits sel.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  run/hold control; starts a fill from IDLE and pauses an active fill.
- add_in  input  add_size  base (top-left) address of the pooling window.
- add_out  output  add_size  registered memory read address for the current window element.
- sel  output  4  registered window slot index for the current element, row-major: sel = r*POOL + c.
- done  output  1  registered; high when all POOL*POOL elements have been issued.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset state:
  - While reset is high, state = IDLE, add_out = 0, sel = 0, done = 0, internal row/col counters = 0 and base register = 0, regardless of clk.
  - Reset asserted mid-fill aborts immediately; the fill restarts from IDLE after release.
- States: IDLE, FILL, DONE.
- IDLE:
  - If enable = 1 at a rising edge: latch base = add_in, drive add_out = add_in, sel = 0, r = c = 0, done = 0, and go to FILL.
  - Otherwise hold all outputs.
  - add_in is sampled only at this start edge; later changes are ignored until the next start.
- FILL, each rising edge with enable = 1:
  - If the current element is not the last, advance c. When c = POOL-1, set c = 0 and advance r.
  - Then drive add_out = base + r*ROW_WIDTH + c and sel = r*POOL + c.
  - If the current element is the last (sel = POOL*POOL-1), set done = 1 and go to DONE. add_out and sel hold their last values.
- FILL, rising edge with enable = 0: hold r, c, add_out and sel (pause); done stays 0.
- Latency:
  - First address appears on the edge that samples enable in IDLE.
  - One new address per enabled cycle.
  - done rises exactly POOL*POOL edges after the start edge when enable is held high. This is one cycle after the last address appears.
- DONE:
  - done = 1 is held, along with add_out and sel, while enable = 1.
  - When enable = 0, clear done and go to IDLE.
  - A new fill therefore requires enable to drop for at least one cycle.
- Arithmetic:
  - Address computed modulo 2^add_size; base near the top of the address range wraps around with no error flag.
  - r*ROW_WIDTH is computed at full width before truncation.
- POOL = 1: one address (add_in, sel = 0), and done rises on the next edge.
- No combinational path from any input to any output.

Test Plan:
- Reset: assert reset asynchronously between clock edges -> add_out = 0, sel = 0, done = 0 immediately. Outputs stay 0 while reset is high.
- Basic fill (defaults, add_in = 0, enable held 1 after reset release):
  - Consecutive edges give (add_out, sel) = (0,0), (1,1), (28,2), (29,3).
  - done = 1 on the next edge and remains 1 while enable stays 1.
- Offset base (add_in = 100): addresses 100, 101, 128, 129 with sel 0..3. Changing add_in to 500 mid-fill has no effect.
- Pause: drop enable for 3 cycles after sel = 1 -> add_out = 1 and sel = 1 held, done = 0. Re-raising enable resumes with 28/2, then 29/3, then done.
- Restart and wrap: after DONE, enable = 0 for one cycle -> done = 0 and state IDLE. Then add_in = 16383 with enable = 1 -> addresses 16383, 0, 27, 28 (mod 2^14).
- Reset mid-fill: assert reset at sel = 2 -> outputs cleared immediately. After release with enable = 1, the sequence restarts from the sampled add_in with sel = 0.
